spi_slave_receiver: RTL and testbench
=====================================

Name: spi_slave_receiver

Overview:
- Far end of the node's outbound SPI link: deserializes instruction words that a neighbouring node's SPI master shifts out on sclk/mosi/cs_n.
- Presents each complete word as a parallel WORD_W-bit instruction plus a valid/check strobe to the node's receiver queue (one instance per direction: left, right, self).
- All pins are sampled in the local clk domain. No logic runs on sclk.

Parameters:
- WORD_W, 32, instruction width in bits; each cs_n frame carries exactly one word.
- FIFO_DEPTH, 2, output word buffer depth; power of two, minimum 2.
- SYNC_STAGES, 2, synchronizer flops on spi_sclk, spi_mosi and spi_cs_n; minimum 2.

Ports:
- clk  in  1  local node clock; must run at ≥4× sclk frequency.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_sclk  in  1  serial clock from remote master; idles low; data sampled on rising edge.
- spi_mosi  in  1  serial data, MSB first.
- spi_cs_n  in  1  frame select, active-low.
- rx_data  out  WORD_W  head-of-buffer word; show-ahead.
- rx_valid  out  1  buffer non-empty; acts as the check/CS strobe to the receiver queue.
- rx_ready  in  1  consumer accepts the head word when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- overflow  out  1  one-cycle pulse when a completed word is dropped.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; bit counter=0; shift register=0; FIFO empty; synchronizer flops set to the idle pin levels (sclk=0, mosi=0, cs_n=1).
- Reset output values: rx_data=0, rx_valid=0, frame_err=0, overflow=0, busy=0.
- Reset mid-frame: the partial word is discarded. After reset release, the FSM stays in IDLE until it sees a fresh cs_n falling edge; a frame already in progress is ignored.
- Edge detection: each event is a compare of the last synchronizer stage against a one-cycle-delayed copy of itself.
  - sclk_rise = synced sclk 0→1.
  - cs_fall / cs_rise = synced cs_n 1→0 / 0→1.
  - mosi is taken from the same synchronizer stage as sclk, so the sampled bit is aligned with its clock edge.
- FSM state IDLE: on cs_fall, clear counter and shift register, go to SHIFT. sclk activity while in IDLE is ignored.
- FSM state SHIFT:
  - Each sclk_rise: shift_reg <= {shift_reg[WORD_W-2:0], mosi}; counter += 1.
  - On the sclk_rise where counter == WORD_W-1: push {shift_reg[WORD_W-2:0], mosi} into the FIFO, go to WAIT_END.
  - On cs_rise with counter < WORD_W: pulse frame_err, discard the partial word, go to IDLE.
  - If cs_rise and sclk_rise occur in the same cycle: process the bit first, then apply the cs_rise rule.
- FSM state WAIT_END:
  - Any sclk_rise pulses frame_err (extra bits). The word already pushed is kept.
  - cs_rise returns the FSM to IDLE.
- Latency: rx_valid rises in the clk cycle after the cycle in which the final sclk_rise is detected. From the final pin edge to rx_valid this is SYNC_STAGES+2 clk cycles.
- FIFO:
  - Show-ahead: rx_data equals the head entry whenever rx_valid=1; rx_data holds its last value while the FIFO is empty.
  - Pop on rx_valid && rx_ready.
  - Push while full with a simultaneous pop: the push is accepted and occupancy is unchanged.
  - Push while full with no pop: the new word is dropped, overflow pulses for one cycle, stored words are unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by one extra pointer bit.
- Width rules: counter is $clog2(WORD_W)+1 bits wide. Frames are exactly WORD_W bits; no partial-word padding.
- frame_err and overflow are never held high for more than one cycle.

Decomposition:
- Shared package link_pkg holds:
  - WORD_W default;
  - the FSM state enum {IDLE, SHIFT, WAIT_END};
  - the sclk idle-level / sample-edge constants shared with master_spi.
- One sub-module, rx_word_fifo: synchronous FIFO parameterized by WORD_W and FIFO_DEPTH, with clk/rst_n, push/data_in, pop, data_out/empty/full.
- Synchronizers and the FSM stay in the top module.

Test Plan:
- Single frame, mosi=0xA5A5_0F3C MSB first, clk = 8× sclk, rx_ready=1 → rx_valid pulses one cycle with rx_data=0xA5A5_0F3C exactly SYNC_STAGES+2 cycles after the 32nd pin edge; frame_err=0.
- Short frame: 20 bits, then cs_n high → frame_err one-cycle pulse; rx_valid stays 0. The next full frame 0x1234_5678 is received correctly.
- Long frame: 34 sclk edges, first 32 bits = 0xDEAD_BEEF → word 0xDEAD_BEEF delivered; frame_err pulses on the 33rd edge (and again on the 34th).
- Backpressure: rx_ready=0, three frames 0x1, 0x2, 0x3 → 0x1 and 0x2 held, overflow pulses on the third. Raising rx_ready then pops 0x1 then 0x2, after which rx_valid=0.
- Full with simultaneous pop: FIFO full (0x1, 0x2), rx_ready=1 in the same cycle the word 0x3 completes → no overflow; output order is 0x1, 0x2, 0x3.
- rst_n asserted mid-frame after 16 bits → all outputs go to 0 asynchronously. After release, the first frame that starts after release delivers 0xCAFE_F00D with no frame_err.

Source files
------------

// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared SPI link constants and receiver FSM state type
//
// Purpose: constants shared by the SPI master and slave ends of a node link,
//          plus the receiver FSM state enumeration.
// Ports:   none (package).

package link_pkg;

   // Default instruction word width carried by one cs_n frame.
   localparam int WORD_W_DEF = 32;

   // Idle levels of the link pins; the slave synchronizers reset to these.
   localparam logic SCLK_IDLE = 1'b0;
   localparam logic MOSI_IDLE = 1'b0;
   localparam logic CS_IDLE   = 1'b1;

   // Level sclk reaches at the sampling edge (1 = data sampled on rising edge).
   localparam logic SCLK_SAMPLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      WAIT_END = 2'd2
   } rx_state_e;

endpackage

// File: rtl/rx_word_fifo.sv
// rtl/rx_word_fifo.sv - show-ahead synchronous word FIFO for the SPI receiver
//
// Purpose: buffers completed instruction words until the receiver queue
//          accepts them. data_out shows the head entry while non-empty and
//          holds the most recently popped word while empty.
// Ports:   clk, rst_n    - clock, async active-low reset
//          push, data_in - write strobe and word (ignored when full unless
//                          a pop happens in the same cycle)
//          pop           - remove head entry (ignored when empty)
//          data_out      - head word (show-ahead)
//          empty, full   - occupancy flags

module rx_word_fifo #(
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [WORD_W-1:0] data_in,
   input  logic              pop,
   output logic [WORD_W-1:0] data_out,
   output logic              empty,
   output logic              full
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic [WORD_W-1:0] last_q;
   logic              wr_en;
   logic              rd_en;

   // The extra MSB on each pointer separates full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign rd_en = pop && !empty;
   // A push while full is accepted only when the head leaves in the same
   // cycle; it then overwrites the slot being vacated.
   assign wr_en = push && (!full || rd_en);

   assign data_out = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
            wr_ptr_q                <= wr_ptr_q + PTR_ONE;
         end
         if (rd_en) begin
            last_q   <= mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/spi_slave_receiver.sv
// rtl/spi_slave_receiver.sv - SPI slave deserializer feeding a node receiver queue
//
// Purpose: samples sclk/mosi/cs_n in the local clk domain, assembles one
//          WORD_W-bit word per cs_n frame (MSB first, rising-edge sampling)
//          and presents completed words through a show-ahead FIFO.
// Ports:   clk, rst_n                  - local clock, async active-low reset
//          spi_sclk, spi_mosi, spi_cs_n - link pins from the remote master
//          rx_data, rx_valid, rx_ready - word output handshake
//          frame_err                   - pulse on short or over-long frame
//          overflow                    - pulse when a completed word is dropped
//          busy                        - FSM not in IDLE

module spi_slave_receiver
   import link_pkg::*;
#(
   parameter int WORD_W      = WORD_W_DEF,
   parameter int FIFO_DEPTH  = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_err,
   output logic              overflow,
   output logic              busy
);

   localparam int CNT_W = $clog2(WORD_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ---------------- pin synchronizers and edge detection ----------------
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic                   sclk_dly_q;
   logic                   cs_dly_q;
   logic [SYNC_STAGES:0]   fill_q;
   logic                   armed_q;
   logic                   sclk_evt_q;
   logic                   mosi_q;
   logic                   cs_fall_q;
   logic                   cs_rise_q;

   logic sclk_s;
   logic mosi_s;
   logic cs_s;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];

   // fill_q marks when the delayed copies hold real pin samples instead of
   // reset values. cs_fall is armed only after cs_n has genuinely been seen
   // high, so a frame already in progress at reset release is ignored.
   // Edge flags are registered together with the matching mosi sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
         mosi_sync_q <= {SYNC_STAGES{MOSI_IDLE}};
         cs_sync_q   <= {SYNC_STAGES{CS_IDLE}};
         sclk_dly_q  <= SCLK_IDLE;
         cs_dly_q    <= CS_IDLE;
         fill_q      <= '0;
         armed_q     <= 1'b0;
         sclk_evt_q  <= 1'b0;
         mosi_q      <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         sclk_dly_q  <= sclk_s;
         cs_dly_q    <= cs_s;
         fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
         armed_q     <= armed_q | (fill_q[SYNC_STAGES] & cs_s & cs_dly_q);
         sclk_evt_q  <= (sclk_s != sclk_dly_q) && (sclk_s == SCLK_SAMPLE_LEVEL);
         mosi_q      <= mosi_s;
         cs_fall_q   <= armed_q & cs_dly_q & ~cs_s;
         cs_rise_q   <= ~cs_dly_q & cs_s;
      end
   end

   // ---------------- receive FSM ----------------
   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic              ferr_q, ferr_d;
   logic              ovf_q;
   logic              push;
   logic [WORD_W-1:0] push_data;
   logic              fifo_empty;
   logic              fifo_full;
   logic              pop;

   assign push_data = {shift_q[WORD_W-2:0], mosi_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      ferr_d  = 1'b0;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall_q) begin
               cnt_d   = '0;
               shift_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (sclk_evt_q) begin
               shift_d = push_data;
               cnt_d   = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  push    = 1'b1;
                  state_d = WAIT_END;
               end
            end
            // The bit in this cycle is counted before judging cs_rise.
            if (cs_rise_q) begin
               if (cnt_d < CNT_FULL) begin
                  ferr_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         WAIT_END: begin
            if (sclk_evt_q) begin
               ferr_d = 1'b1;
            end
            if (cs_rise_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         ferr_q  <= ferr_d;
         ovf_q   <= push & fifo_full & ~pop;
      end
   end

   // ---------------- output buffer ----------------
   assign pop = rx_valid & rx_ready;

   rx_word_fifo #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .data_in  (push_data),
      .pop      (pop),
      .data_out (rx_data),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   assign rx_valid  = ~fifo_empty;
   assign frame_err = ferr_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb/tb_spi_slave_receiver.sv - directed self-checking bench for spi_slave_receiver

module tb_spi_slave_receiver;

   logic        clk;
   logic        rst_n;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_cs_n;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        frame_err;
   logic        overflow;
   logic        busy;

   int n_checks = 0;
   int n_bad    = 0;

   spi_slave_receiver #(
      .WORD_W      (32),
      .FIFO_DEPTH  (2),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_cs_n  (spi_cs_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: accepted words, error pulses and over-long pulses.
   logic [31:0] got_q[$];
   int ferr_cnt = 0;
   int ovf_cnt  = 0;
   int long_cnt = 0;
   logic ferr_prev = 1'b0;
   logic ovf_prev  = 1'b0;

   always @(negedge clk) begin
      if (rst_n && rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if ((frame_err && ferr_prev) || (overflow && ovf_prev)) long_cnt++;
      ferr_prev = frame_err;
      ovf_prev  = overflow;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      spi_mosi = b;
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] w, input int nbits);
      spi_cs_n = 1'b0;
      tick(4);
      for (int i = 0; i < nbits; i++) begin
         send_bit((i < 32) ? w[31 - i] : 1'b0);
      end
      tick(4);
      spi_cs_n = 1'b1;
      tick(8);
   endtask

   // Opens a frame and sends the first 31 bits, stopping with sclk low and
   // the final bit on mosi, just before the last rising edge.
   task automatic frame_head(input logic [31:0] w);
      spi_cs_n = 1'b0;
      tick(4);
      for (int i = 0; i < 31; i++) send_bit(w[31 - i]);
      spi_mosi = w[0];
      tick(4);
   endtask

   task automatic frame_tail();
      spi_sclk = 1'b0;
      tick(4);
      spi_cs_n = 1'b1;
      tick(8);
   endtask

   function automatic logic [31:0] next_word();
      if (got_q.size() == 0) return 32'hxxxx_xxxx;
      return got_q.pop_front();
   endfunction

   int f0;
   int o0;

   initial begin
      rst_n    = 1'b0;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      spi_cs_n = 1'b1;
      rx_ready = 1'b0;
      tick(3);

      // Reset state.
      check_eq("rst_rx_data", rx_data, 32'h0);
      check_eq("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
      check_eq("rst_frame_err", {31'b0, frame_err}, 32'h0);
      check_eq("rst_overflow", {31'b0, overflow}, 32'h0);
      check_eq("rst_busy", {31'b0, busy}, 32'h0);
      rst_n = 1'b1;
      tick(10);

      // Single frame with latency measured from the final sclk rising edge.
      rx_ready = 1'b1;
      f0 = ferr_cnt;
      frame_head(32'hA5A5_0F3C);
      check_eq("busy_in_frame", {31'b0, busy}, 32'h1);
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("lat_valid_early", {31'b0, rx_valid}, 32'h0);
      @(negedge clk);
      check_eq("lat_valid_at4", {31'b0, rx_valid}, 32'h1);
      check_eq("lat_data", rx_data, 32'hA5A5_0F3C);
      @(negedge clk);
      check_eq("lat_valid_after", {31'b0, rx_valid}, 32'h0);
      check_eq("hold_data_empty", rx_data, 32'hA5A5_0F3C);
      tick(1);
      frame_tail();
      check_eq("single_word", next_word(), 32'hA5A5_0F3C);
      check_eq("single_ferr", ferr_cnt - f0, 32'd0);
      check_eq("busy_idle", {31'b0, busy}, 32'h0);

      // Short frame, then a good frame.
      f0 = ferr_cnt;
      send_frame(32'hFFFF_FFFF, 20);
      check_eq("short_ferr", ferr_cnt - f0, 32'd1);
      check_eq("short_no_word", got_q.size(), 32'd0);
      send_frame(32'h1234_5678, 32);
      check_eq("after_short_word", next_word(), 32'h1234_5678);
      check_eq("after_short_ferr", ferr_cnt - f0, 32'd1);

      // Long frame: 34 edges.
      f0 = ferr_cnt;
      send_frame(32'hDEAD_BEEF, 34);
      check_eq("long_word", next_word(), 32'hDEAD_BEEF);
      check_eq("long_ferr", ferr_cnt - f0, 32'd2);

      // Backpressure: third word overflows.
      rx_ready = 1'b0;
      o0 = ovf_cnt;
      send_frame(32'h1, 32);
      send_frame(32'h2, 32);
      send_frame(32'h3, 32);
      check_eq("bp_overflow", ovf_cnt - o0, 32'd1);
      check_eq("bp_valid", {31'b0, rx_valid}, 32'h1);
      check_eq("bp_head", rx_data, 32'h1);
      rx_ready = 1'b1;
      tick(4);
      check_eq("bp_pop1", next_word(), 32'h1);
      check_eq("bp_pop2", next_word(), 32'h2);
      check_eq("bp_drained", got_q.size(), 32'd0);
      check_eq("bp_valid_end", {31'b0, rx_valid}, 32'h0);

      // Full FIFO with a pop in the same cycle the next word completes.
      rx_ready = 1'b0;
      send_frame(32'h1, 32);
      send_frame(32'h2, 32);
      o0 = ovf_cnt;
      frame_head(32'h3);
      spi_sclk = 1'b1;
      tick(3);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(3);
      frame_tail();
      check_eq("simul_overflow", ovf_cnt - o0, 32'd0);
      check_eq("simul_head", rx_data, 32'h2);
      rx_ready = 1'b1;
      tick(4);
      check_eq("simul_w1", next_word(), 32'h1);
      check_eq("simul_w2", next_word(), 32'h2);
      check_eq("simul_w3", next_word(), 32'h3);

      // Reset in the middle of a frame while a word is buffered.
      rx_ready = 1'b0;
      send_frame(32'h0000_0055, 32);
      f0 = ferr_cnt;
      spi_cs_n = 1'b0;
      tick(4);
      for (int i = 0; i < 16; i++) send_bit(i[0]);
      check_eq("pre_rst_busy", {31'b0, busy}, 32'h1);
      check_eq("pre_rst_valid", {31'b0, rx_valid}, 32'h1);
      rst_n = 1'b0;
      #2;
      check_eq("arst_rx_data", rx_data, 32'h0);
      check_eq("arst_rx_valid", {31'b0, rx_valid}, 32'h0);
      check_eq("arst_busy", {31'b0, busy}, 32'h0);
      check_eq("arst_ferr_ovf", {30'b0, frame_err, overflow}, 32'h0);
      tick(2);
      rst_n = 1'b1;
      rx_ready = 1'b1;
      for (int i = 0; i < 16; i++) send_bit(~i[0]);
      tick(4);
      spi_cs_n = 1'b1;
      tick(8);
      check_eq("stale_frame_ignored", got_q.size(), 32'd0);
      send_frame(32'hCAFE_F00D, 32);
      check_eq("post_rst_word", next_word(), 32'hCAFE_F00D);
      check_eq("post_rst_ferr", ferr_cnt - f0, 32'd0);

      check_eq("pulse_width", long_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
